// File: rtl/alu_divider.sv
// Sequential radix-2 restoring divider for the ALU DIV operation (quotient on Y1, remainder on Y2).
// Define ALU_DIV_SIGNED_EN to honour 'form' (signed division); otherwise every division is unsigned.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             form,
    input  logic [1:0]       vec,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] C,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_q;
    logic        busy_q, done_q, err_q;
    logic [31:0] y1_q, y2_q;
    logic [31:0] rem_q, quo_q, divMag_q;
    logic [5:0]  cnt_q;
    logic [1:0]  vec_q;
    logic        sign_q, quoNeg_q, remNeg_q;

    logic        signedIn, aNeg, cNeg;
    logic [5:0]  nBits;
    logic [31:0] aTrunc, cTrunc, aSx, cSx, aMag, cMag;
    logic [32:0] remShift, diff;
    logic [31:0] rem_d, quo_d, quoFix, remFix;

    function automatic logic [5:0] vecBits(input logic [1:0] pv);
        case (pv)
            2'b00:   return 6'd8;
            2'b01:   return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    // Keep the low n bits of v and extend them to 32 bits (sign or zero).
    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] pv, input logic sgn);
        case (pv)
            2'b00:   return sgn ? {{24{v[7]}}, v[7:0]} : {24'b0, v[7:0]};
            2'b01:   return sgn ? {{16{v[15]}}, v[15:0]} : {16'b0, v[15:0]};
            default: return v;
        endcase
    endfunction

    always_comb begin
`ifdef ALU_DIV_SIGNED_EN
        signedIn = form;
`else
        signedIn = form & 1'b0;
`endif
        nBits  = vecBits(vec);
        aTrunc = extend(A, vec, 1'b0);
        cTrunc = extend(C, vec, 1'b0);
        aSx    = extend(A, vec, 1'b1);
        cSx    = extend(C, vec, 1'b1);
        aNeg   = signedIn & aSx[31];
        cNeg   = signedIn & cSx[31];
        aMag   = aNeg ? (32'd0 - aSx) : aTrunc;
        cMag   = cNeg ? (32'd0 - cSx) : cTrunc;

        // Dividend is left-aligned so its MSB shifts out first; quotient bits fill in from the LSB.
        remShift = {rem_q, quo_q[31]};
        diff     = remShift - {1'b0, divMag_q};
        rem_d    = diff[32] ? remShift[31:0] : diff[31:0];
        quo_d    = {quo_q[30:0], ~diff[32]};

        quoFix = quoNeg_q ? (32'd0 - quo_q) : quo_q;
        remFix = remNeg_q ? (32'd0 - rem_q) : rem_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            y1_q     <= '0;
            y2_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            divMag_q <= '0;
            cnt_q    <= '0;
            vec_q    <= '0;
            sign_q   <= 1'b0;
            quoNeg_q <= 1'b0;
            remNeg_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        vec_q  <= vec;
                        sign_q <= signedIn;
                        if (vec == 2'b11) begin
                            err_q   <= 1'b1;
                            y1_q    <= '0;
                            y2_q    <= '0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (cTrunc == 32'd0) begin
                            err_q   <= 1'b1;
                            y1_q    <= extend(32'hFFFF_FFFF, vec, signedIn);
                            y2_q    <= extend(A, vec, signedIn);
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q    <= 1'b0;
                            rem_q    <= '0;
                            quo_q    <= aMag << (6'd32 - nBits);
                            divMag_q <= cMag;
                            quoNeg_q <= aNeg ^ cNeg;
                            remNeg_q <= aNeg;
                            cnt_q    <= nBits;
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) state_q <= FIX;
                end
                FIX: begin
                    // Most-negative / -1 needs no special case: magnitude 2^(n-1) re-extends to most-negative.
                    y1_q    <= extend(quoFix, vec_q, sign_q);
                    y2_q    <= extend(remFix, vec_q, sign_q);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign Y1   = y1_q;
    assign Y2   = y2_q;

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: directed test-plan scenarios plus randomized ops
// checked against an arithmetic reference model (honours ALU_DIV_SIGNED_EN when defined).
module tb_alu_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        form = 1'b0;
    logic [1:0]  vec = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] C = '0;
    logic        busy, done, err;
    logic [31:0] Y1, Y2;

    int nCompared = 0;
    int nMismatched = 0;

    alu_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .form(form), .vec(vec),
        .A(A), .C(C), .busy(busy), .done(done), .err(err), .Y1(Y1), .Y2(Y2)
    );

    always #5 clk = ~clk;

    // Take the low n bits of val and extend them to 32 bits.
    function automatic logic [31:0] modelExt(input longint val, input int n, input bit sgn);
        longint mask = (64'sd1 <<< n) - 1;
        longint v = val & mask;
        bit neg = ((v >>> (n - 1)) & 1) != 0;
        return (sgn && neg) ? 32'(v | ~mask) : 32'(v);
    endfunction

    task automatic refModel(input bit f, input logic [1:0] v, input logic [31:0] a, input logic [31:0] c,
                            output logic [31:0] q, output logic [31:0] r, output logic e, output int lat);
        int n;
        longint mask, at, ct, sa, sc;
        bit sgn;
`ifdef ALU_DIV_SIGNED_EN
        sgn = f;
`else
        sgn = 1'b0;
`endif
        if (v == 2'b11) begin
            q = '0; r = '0; e = 1'b1; lat = 1;
            return;
        end
        n = 8 << v;
        mask = (64'sd1 <<< n) - 1;
        at = longint'({32'b0, a}) & mask;
        ct = longint'({32'b0, c}) & mask;
        if (ct == 0) begin
            e = 1'b1; lat = 1;
            q = modelExt(mask, n, sgn);
            r = modelExt(at, n, sgn);
        end else begin
            e = 1'b0; lat = n + 2;
            if (sgn) begin
                sa = (at >= (64'sd1 <<< (n - 1))) ? at - (64'sd1 <<< n) : at;
                sc = (ct >= (64'sd1 <<< (n - 1))) ? ct - (64'sd1 <<< n) : ct;
                q = modelExt(sa / sc, n, sgn);
                r = modelExt(sa % sc, n, sgn);
            end else begin
                q = modelExt(at / ct, n, sgn);
                r = modelExt(at % ct, n, sgn);
            end
        end
    endtask

    // Present an op for one sampling edge, then scramble the inputs.
    task automatic launch(input bit f, input logic [1:0] v, input logic [31:0] a, input logic [31:0] c);
        form = f; vec = v; A = a; C = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        form = 1'($urandom); vec = 2'($urandom); A = $urandom; C = $urandom;
    endtask

    task automatic waitDone(input int pokeCycle, output int lat, output int busyCnt,
                            output logic [31:0] y1, output logic [31:0] y2, output logic e);
        lat = -1; busyCnt = 0; y1 = '0; y2 = '0; e = 1'b0;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            if (k == pokeCycle) begin
                start = 1'b1; vec = 2'b10; A = $urandom; C = $urandom | 32'd1;
            end else begin
                start = 1'b0;
            end
            if (busy) busyCnt++;
            if (done) begin
                lat = k; y1 = Y1; y2 = Y2; e = err;
            end
        end
        start = 1'b0;
    endtask

    task automatic runOp(input bit f, input logic [1:0] v, input logic [31:0] a, input logic [31:0] c,
                         input int pokeCycle, output int lat, output int busyCnt,
                         output logic [31:0] y1, output logic [31:0] y2, output logic e);
        @(negedge clk);
        launch(f, v, a, c);
        waitDone(pokeCycle, lat, busyCnt, y1, y2, e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nCompared++;
        if ({busy, done, err, Y1, Y2} !== 67'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b err=%b Y1=%h Y2=%h, need all 0", busy, done, err, Y1, Y2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_unsigned();
        int lat, bc; logic [31:0] y1, y2; logic e;
        runOp(1'b0, 2'b10, 32'd100, 32'd7, 0, lat, bc, y1, y2, e);
        nCompared += 3;
        if (lat !== 34) begin nMismatched++; $display("[TB] FAIL full_latency: got %0d, need 34", lat); end
        if (bc !== 33) begin nMismatched++; $display("[TB] FAIL full_busy_cycles: got %0d, need 33", bc); end
        if ({e, y1, y2} !== {1'b0, 32'd14, 32'd2}) begin
            nMismatched++; $display("[TB] FAIL full_result: got err=%b Y1=%h Y2=%h, need 0/0000000e/00000002", e, y1, y2);
        end
    endtask

    task automatic test_char_signed();
        int lat, bc; logic [31:0] y1, y2, eq, er; logic e;
`ifdef ALU_DIV_SIGNED_EN
        eq = 32'hFFFF_FFFD; er = 32'hFFFF_FFFF;
`else
        eq = 32'h0000_007C; er = 32'h0000_0001;
`endif
        runOp(1'b1, 2'b00, 32'h0000_00F9, 32'h0000_0002, 0, lat, bc, y1, y2, e);
        nCompared += 2;
        if (lat !== 10) begin nMismatched++; $display("[TB] FAIL char_latency: got %0d, need 10", lat); end
        if ({e, y1, y2} !== {1'b0, eq, er}) begin
            nMismatched++; $display("[TB] FAIL char_result: got err=%b Y1=%h Y2=%h, need 0/%h/%h", e, y1, y2, eq, er);
        end
    endtask

    task automatic test_overflow();
        int lat, bc, elat; logic [31:0] y1, y2, eq, er; logic e, ee;
        refModel(1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, eq, er, ee, elat);
        runOp(1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bc, y1, y2, e);
        nCompared++;
        if ({lat, e, y1, y2} !== {elat, ee, eq, er}) begin
            nMismatched++; $display("[TB] FAIL overflow: got lat=%0d err=%b Y1=%h Y2=%h, need %0d/%b/%h/%h", lat, e, y1, y2, elat, ee, eq, er);
        end
    endtask

    task automatic test_reserved();
        int lat, bc; logic [31:0] y1, y2; logic e;
        runOp(1'b0, 2'b11, 32'h1234_5678, 32'd3, 0, lat, bc, y1, y2, e);
        nCompared++;
        if ({lat, bc, e, y1, y2} !== {32'd1, 32'd0, 1'b1, 32'd0, 32'd0}) begin
            nMismatched++; $display("[TB] FAIL reserved_vec: got lat=%0d busy=%0d err=%b Y1=%h Y2=%h, need 1/0/1/0/0", lat, bc, e, y1, y2);
        end
    endtask

    task automatic test_div_zero();
        int lat, bc; logic [31:0] y1, y2; logic e;
        runOp(1'b0, 2'b01, 32'h0000_1234, 32'h0000_0000, 0, lat, bc, y1, y2, e);
        nCompared++;
        if ({lat, e, y1, y2} !== {32'd1, 1'b1, 32'h0000_FFFF, 32'h0000_1234}) begin
            nMismatched++; $display("[TB] FAIL div_zero: got lat=%0d err=%b Y1=%h Y2=%h, need 1/1/0000ffff/00001234", lat, e, y1, y2);
        end
    endtask

    task automatic test_mid_reset();
        bit sawDone = 1'b0;
        @(negedge clk);
        launch(1'b0, 2'b10, 32'hDEAD_BEEF, 32'd13);
        for (int k = 1; k <= 10; k++) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        nCompared++;
        if ({busy, done, Y1, Y2} !== 66'd0) begin
            nMismatched++; $display("[TB] FAIL mid_reset_state: got busy=%b done=%b Y1=%h Y2=%h, need all 0", busy, done, Y1, Y2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        nCompared++;
        if (sawDone !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_reset_no_done: got done pulse=1, need 0"); end
    endtask

    task automatic test_ignored_start();
        int lat, bc, elat; logic [31:0] y1, y2, eq, er, a, c; logic e, ee;
        a = $urandom; c = ($urandom >> $urandom_range(4, 28)) | 32'd1;
        refModel(1'b0, 2'b10, a, c, eq, er, ee, elat);
        runOp(1'b0, 2'b10, a, c, 5, lat, bc, y1, y2, e);
        nCompared++;
        if ({lat, e, y1, y2} !== {elat, ee, eq, er}) begin
            nMismatched++; $display("[TB] FAIL ignored_start: got lat=%0d err=%b Y1=%h Y2=%h, need %0d/%b/%h/%h", lat, e, y1, y2, elat, ee, eq, er);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, elat; logic [31:0] y1, y2, eq, er; logic e, ee;
        @(negedge clk);
        launch(1'b0, 2'b00, 32'd200, 32'd9);
        lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k; y1 = Y1; y2 = Y2;
                start = 1'b1; form = 1'b0; vec = 2'b00; A = 32'd50; C = 32'd3;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        nCompared += 2;
        if ({lat, y1, y2} !== {32'd10, 32'd22, 32'd2}) begin
            nMismatched++; $display("[TB] FAIL b2b_first: got lat=%0d Y1=%h Y2=%h, need 10/00000016/00000002", lat, y1, y2);
        end
        @(negedge clk);
        if ({busy, done} !== 2'b00) begin
            nMismatched++; $display("[TB] FAIL b2b_start_during_done: got busy=%b done=%b, need 0/0", busy, done);
        end
        refModel(1'b0, 2'b01, 32'h0000_BEEF, 32'h0000_0123, eq, er, ee, elat);
        launch(1'b0, 2'b01, 32'h0000_BEEF, 32'h0000_0123);
        waitDone(0, lat, bc, y1, y2, e);
        nCompared++;
        if ({lat, e, y1, y2} !== {elat, ee, eq, er}) begin
            nMismatched++; $display("[TB] FAIL b2b_second: got lat=%0d err=%b Y1=%h Y2=%h, need %0d/%b/%h/%h", lat, e, y1, y2, elat, ee, eq, er);
        end
    endtask

    task automatic test_random();
        int lat, bc, elat, n, sel; logic [31:0] y1, y2, eq, er, a, c; logic e, ee, f; logic [1:0] v;
        for (int i = 0; i < 40; i++) begin
            f = 1'($urandom);
            sel = $urandom_range(0, 9);
            v = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            n = 8 << (v == 2'b11 ? 2 : v);
            a = ($urandom_range(0, 7) == 0) ? (32'd1 << (n - 1)) : $urandom;
            sel = $urandom_range(0, 9);
            c = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'($urandom_range(1, 15)) : $urandom;
            refModel(f, v, a, c, eq, er, ee, elat);
            runOp(f, v, a, c, 0, lat, bc, y1, y2, e);
            nCompared++;
            if ({lat, e, y1, y2} !== {elat, ee, eq, er}) begin
                nMismatched++;
                $display("[TB] FAIL random_%0d f=%b v=%b A=%h C=%h: got lat=%0d err=%b Y1=%h Y2=%h, need %0d/%b/%h/%h",
                         i, f, v, a, c, lat, e, y1, y2, elat, ee, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_unsigned();
        test_char_signed();
        test_overflow();
        test_reserved();
        test_div_zero();
        test_mid_reset();
        test_ignored_start();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
